systolic_result_drain: RTL
==========================

// Module: systolic_result_drain
// PURPOSE
//  Consumer end of the systolic array's done/C_out result interface. Captures a
//  ROWSxCOLS accumulator tile on the array's one-cycle done pulse, then requantizes
//  each element and streams it out row-major over a valid/ready stream. Sits between
//  the systolic core and the output-activation writeback path.
// PARAMETERS
//  ACCW   32  accumulator width of incoming tile elements (signed)
//  ROWS   4   tile rows (>=2)
//  COLS   4   tile cols (>=2)
//  OUTW   8   output element width (signed), OUTW < ACCW
//  SHIFT  0   arithmetic right shift applied before saturation, 0..ACCW-1
// PORTS
//  clk         in   1                  clock, rising edge
//  rst_n       in   1                  asynchronous, active-low reset
//  done_in     in   1                  one-cycle pulse: C_in valid this cycle
//  C_in        in   ACCW x[ROWS][COLS] signed accumulator tile
//  tile_ready  out  1                  comb: a done_in this cycle will be captured
//  tile_drop   out  1                  one-cycle pulse: done_in arrived and was lost
//  m_valid     out  1                  output beat valid
//  m_ready     in   1                  downstream accepts beat
//  m_data      out  OUTW               signed requantized element
//  m_row       out  $clog2(ROWS)       row index of beat
//  m_col       out  $clog2(COLS)       col index of beat
//  m_last      out  1                  final beat of tile (row ROWS-1, col COLS-1)
//  m_sat       out  1                  beat was clamped
// BEHAVIOUR
//  - Reset (async): state IDLE, m_valid=0, idx=0, tile_drop=0, capture buffer all 0.
//  - States: IDLE, DRAIN. Beat handshake hs = m_valid & m_ready.
//  - IDLE: done_in=1 -> buffer<=C_in, idx<=0, ->DRAIN; m_valid=1 next cycle (latency 1).
//  - DRAIN: m_valid=1; outputs reflect buffer[idx]; on hs idx++ (row-major, col fastest).
//  - Last beat hs: if done_in same cycle -> capture new tile, idx<=0, stay DRAIN
//    (back-to-back, no bubble); else ->IDLE, m_valid<=0.
//  - done_in in DRAIN without last-beat hs: tile ignored, tile_drop=1 next cycle, stream
//    unaffected.
//  - tile_ready = (state==IDLE) | (state==DRAIN & hs & m_last).
//  - m_data/m_row/m_col/m_last/m_sat held stable while m_valid & !m_ready.
//  - Outputs driven from registered buffer/idx only; no comb path m_ready->m_data.
//  - Requant: v = buffer[idx] >>> SHIFT (sign-preserving); clamp to
//    [-2^(OUTW-1), 2^(OUTW-1)-1]; m_sat=1 iff clamped.
//  - m_last=1 iff idx==ROWS*COLS-1. Only done_in edge triggers capture; level ignored.
// CONFIGURATION
//  - SYS_DRAIN_RELU_EN defined: v<0 -> 0 before clamp (m_sat=0 for that case).
//  - Undefined: full signed range passed to clamp.
// STRUCTURE
//  - systolic_pkg: drain_state_t enum {IDLE, DRAIN}; sat/clamp helper function.
//  - Sub-module systolic_requant_sat: combinational shift + optional ReLU + clamp,
//    ACCW->OUTW, outputs data and sat flag.
// TESTING
//  1. C_in[r][c]=4r+c, m_ready=1, done_in pulse -> m_valid next cycle, 16 beats 0..15
//     row-major, m_last only on beat 15, then m_valid=0.
//  2. Same tile, m_ready toggling 1/0 -> beats held during stalls, order 0..15 kept.
//  3. C_in[0][0]=300,[0][1]=-300,SHIFT=0 -> 127/m_sat=1, -128/m_sat=1; SHIFT=2, 300 -> 75,
//     m_sat=0. With SYS_DRAIN_RELU_EN: -5 -> 0.
//  4. done_in at beat 6 of drain -> tile_drop=1 one cycle, tile_ready=0 then, beats 6..15
//     of first tile unchanged.
//  5. done_in coincident with last-beat hs, m_ready=1 -> next cycle beat 0 of new tile,
//     no m_valid gap, tile_drop=0.
//  6. rst_n low at beat 9 -> m_valid=0 immediately; after release, new done_in drains
//     from beat 0.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic result drain path.
// Optional ReLU before saturation is enabled by defining SYS_DRAIN_RELU_EN.
package systolic_pkg;

   // Drain controller states: waiting for a tile, or streaming one out
   typedef enum logic {
      IDLE  = 1'b0,
      DRAIN = 1'b1
   } drain_state_t;

   // True when a sign-extended value does not fit in a signed outw-bit field
   function automatic logic outOfRange(input logic signed [63:0] v, input int outw);
      logic signed [63:0] maxV;
      logic signed [63:0] minV;
      maxV = (64'sd1 <<< (outw - 1)) - 64'sd1;
      minV = -(64'sd1 <<< (outw - 1));
      return (v > maxV) || (v < minV);
   endfunction

endpackage

// File: rtl/systolic_requant_sat.sv
// Combinational requantizer: arithmetic shift, optional ReLU, signed clamp ACCW->OUTW.
// Defining SYS_DRAIN_RELU_EN forces negative values to zero before the clamp.
module systolic_requant_sat
   import systolic_pkg::*;
#(
   parameter int ACCW  = 32,
   parameter int OUTW  = 8,
   parameter int SHIFT = 0
) (
   input  logic [ACCW-1:0] acc_i,
   output logic [OUTW-1:0] data_o,
   output logic            sat_o
);

   logic signed [ACCW-1:0] shifted;
   logic signed [63:0]     wide;

   // Scale down, optionally rectify, then clamp to the signed output range
   always_comb begin
      shifted = $signed(acc_i) >>> SHIFT;
`ifdef SYS_DRAIN_RELU_EN
      if (shifted < 0) shifted = '0;
`endif
      wide  = 64'(shifted);
      sat_o = outOfRange(wide, OUTW);
      if (!sat_o)
         data_o = shifted[OUTW-1:0];
      else if (shifted[ACCW-1])
         data_o = {1'b1, {(OUTW-1){1'b0}}};
      else
         data_o = {1'b0, {(OUTW-1){1'b1}}};
   end

endmodule

// File: rtl/systolic_result_drain.sv
// Captures a ROWSxCOLS accumulator tile on a done pulse and streams it out
// row-major, requantized, over a valid/ready interface.
// Build option SYS_DRAIN_RELU_EN enables ReLU inside the requantizer.
module systolic_result_drain
   import systolic_pkg::*;
#(
   parameter int ACCW  = 32,
   parameter int ROWS  = 4,
   parameter int COLS  = 4,
   parameter int OUTW  = 8,
   parameter int SHIFT = 0
) (
   input  logic                                    clk,
   input  logic                                    rst_n,
   input  logic                                    done_in,
   input  logic [ROWS-1:0][COLS-1:0][ACCW-1:0]     C_in,
   output logic                                    tile_ready,
   output logic                                    tile_drop,
   output logic                                    m_valid,
   input  logic                                    m_ready,
   output logic [OUTW-1:0]                         m_data,
   output logic [$clog2(ROWS)-1:0]                 m_row,
   output logic [$clog2(COLS)-1:0]                 m_col,
   output logic                                    m_last,
   output logic                                    m_sat
);

   localparam int RW = $clog2(ROWS);
   localparam int CW = $clog2(COLS);

   drain_state_t                          stateQ;
   logic                                  validQ;
   logic                                  dropQ;
   logic                                  donePrevQ;
   logic [ROWS-1:0][COLS-1:0][ACCW-1:0]   bufQ;
   logic [RW-1:0]                         rowQ;
   logic [CW-1:0]                         colQ;

   logic            hs;
   logic            lastBeat;
   logic            doneEvent;
   logic            capture;
   logic [ACCW-1:0] curElem;

   // A done_in held high is one event: only its rising edge may capture or drop
   assign doneEvent  = done_in & ~donePrevQ;
   assign hs         = validQ & m_ready;
   assign lastBeat   = (rowQ == RW'(ROWS - 1)) && (colQ == CW'(COLS - 1));
   assign tile_ready = (stateQ == IDLE) | ((stateQ == DRAIN) & hs & lastBeat);
   assign capture    = doneEvent & tile_ready;
   assign curElem    = bufQ[rowQ][colQ];

   // Tile capture, row-major beat stepping and drop reporting
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stateQ    <= IDLE;
         validQ    <= 1'b0;
         dropQ     <= 1'b0;
         donePrevQ <= 1'b0;
         bufQ      <= '0;
         rowQ      <= '0;
         colQ      <= '0;
      end else begin
         donePrevQ <= done_in;
         dropQ     <= doneEvent & ~tile_ready;
         if (capture) begin
            bufQ   <= C_in;
            rowQ   <= '0;
            colQ   <= '0;
            stateQ <= DRAIN;
            validQ <= 1'b1;
         end else if (hs) begin
            if (lastBeat) begin
               stateQ <= IDLE;
               validQ <= 1'b0;
               rowQ   <= '0;
               colQ   <= '0;
            end else if (colQ == CW'(COLS - 1)) begin
               colQ <= '0;
               rowQ <= rowQ + RW'(1);
            end else begin
               colQ <= colQ + CW'(1);
            end
         end
      end
   end

   systolic_requant_sat #(
      .ACCW  (ACCW),
      .OUTW  (OUTW),
      .SHIFT (SHIFT)
   ) u_requant (
      .acc_i  (curElem),
      .data_o (m_data),
      .sat_o  (m_sat)
   );

   assign m_valid   = validQ;
   assign m_row     = rowQ;
   assign m_col     = colQ;
   assign m_last    = lastBeat;
   assign tile_drop = dropQ;

endmodule
